sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter RESERVE, default 4, free-slot threshold for prog_full; legal range 0..DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy threshold for prog_empty; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 SHALL use one clock and a synchronous, active-high reset, exposed as the ports below.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 full  output  1  occupancy == DEPTH.
REQ-012 prog_full  output  1  occupancy >= DEPTH-RESERVE.
REQ-013 overflow  output  1  one-cycle pulse on a rejected write.
REQ-014 rd_en  input  1  read request (pop).
REQ-015 rd_data  output  DATA_WIDTH  read data.
REQ-016 rd_valid  output  1  rd_data qualifier; only meaningful when FWFT=0.
REQ-017 empty  output  1  occupancy == 0.
REQ-018 has_data  output  1  always the exact inverse of empty.
REQ-019 prog_empty  output  1  occupancy <= AE_LEVEL.
REQ-020 underflow  output  1  one-cycle pulse on a rejected read.
REQ-021 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-022 Write accepted iff wr_en && !full, sampled on the same edge; the word is stored at the write pointer, and the pointer advances modulo DEPTH.
REQ-023 Read accepted iff rd_en && !empty, sampled on the same edge; the read pointer advances modulo DEPTH.
REQ-024 count updates on the edge: +1 for write only, -1 for read only, unchanged for both or neither; never exceeds DEPTH or goes below 0.
REQ-025 full, prog_full, empty, has_data and prog_empty SHALL be registered and consistent with count in the same cycle; no combinational path from wr_en/rd_en to any flag.
REQ-026 Latency: an accepted write to an empty FIFO deasserts empty exactly one cycle after the write edge.
REQ-027 When full, wr_en && rd_en SHALL accept only the read; count becomes DEPTH-1 and overflow pulses.
REQ-028 When empty, wr_en && rd_en SHALL accept only the write; count becomes 1 and underflow pulses.
REQ-029 overflow SHALL be 1 for exactly the cycle after an edge with wr_en && full; the data is dropped and no state changes.
REQ-030 underflow SHALL be 1 for exactly the cycle after an edge with rd_en && empty; no state changes.
REQ-031 FWFT=0: rd_data is registered and updated one cycle after an accepted read; rd_valid pulses in that cycle; otherwise rd_data holds its value and rd_valid=0.
REQ-032 FWFT=1: rd_data always shows the head entry while has_data=1; rd_en pops the entry; rd_valid tracks has_data.
REQ-033 Data SHALL leave in write order across pointer wrap-around.
REQ-034 Invariants, held every cycle: full implies prog_full; empty implies prog_empty; has_data == !empty; never full && empty.

Reset
REQ-035 While rst=1 at an edge: pointers and count clear to 0, empty=1, has_data=0, prog_empty=1, full=0, prog_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0.
REQ-036 wr_en and rd_en SHALL be ignored during reset; reset mid-operation discards all stored contents, and flags take reset values one cycle after the rst edge.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, RESERVE=4, AE_LEVEL=2)
REQ-037 Fill 0..15 from empty -> prog_empty clears after the 3rd write, prog_full sets after the 12th (count=12), full after the 16th; a 17th write -> overflow=1 for one cycle, count=16.
REQ-038 FWFT=0, drain the full FIFO -> rd_data 0..15 in order, each with a one-cycle rd_valid; empty=1 after the 16th read; an extra read -> underflow=1, rd_valid=0.
REQ-039 At count=8, drive simultaneous write and read for 100 cycles -> count stays 8 and order is preserved; at full, simultaneous write and read -> count=15 and overflow=1.
REQ-040 FWFT=1, write 0xA5 to empty -> next cycle has_data=1 and rd_data=0xA5 with no rd_en; one rd_en -> empty=1.
REQ-041 Assert rst for one cycle at count=8 -> next cycle count=0, empty=1, has_data=0; a subsequent write 0x3C then read returns 0x3C only.
REQ-042 500 cycles of LFSR-random wr_en/rd_en with an every-cycle monitor -> zero REQ-034 invariant violations, and count equals accepted writes minus accepted reads.

Source files
------------

// File: rtl/sync_fifo_flags.sv
//------------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with registered status flags and two read styles.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : log2 of the depth (DEPTH = 2**ADDR_WIDTH entries)
//   RESERVE    : prog_full asserts when free slots <= RESERVE (0..DEPTH-1)
//   AE_LEVEL   : prog_empty asserts when occupancy <= AE_LEVEL (0..DEPTH-1)
//   FWFT       : 0 = registered read data one cycle after a pop,
//                1 = first-word-fall-through (head entry always visible)
//
// Ports
//   clk        : sole clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   wr_en      : write request, accepted when the FIFO is not full
//   wr_data    : word to write
//   full       : occupancy == DEPTH
//   prog_full  : occupancy >= DEPTH-RESERVE
//   overflow   : one-cycle pulse after a write attempted while full
//   rd_en      : read (pop) request, accepted when the FIFO is not empty
//   rd_data    : read data
//   rd_valid   : FWFT=0: pulses with fresh rd_data; FWFT=1: follows has_data
//   empty      : occupancy == 0
//   has_data   : inverse of empty
//   prog_empty : occupancy <= AE_LEVEL
//   underflow  : one-cycle pulse after a read attempted while empty
//   count      : current occupancy, 0..DEPTH
//------------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RESERVE    = 4,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  prog_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  has_data,
    output logic                  prog_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Thresholds pre-sized to the occupancy counter so every flag compare
    // is width-matched.
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PF_LVL    = (ADDR_WIDTH+1)'(DEPTH - RESERVE);
    localparam logic [ADDR_WIDTH:0] PE_LVL    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [ADDR_WIDTH:0]   count_next;

    // Acceptance is judged against the registered flags, so when full a
    // simultaneous read/write only pops, and when empty it only pushes.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Exact inverse of a register, so it can never disagree with empty.
    assign has_data = ~empty;

    // Next occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and all flags. The flags are computed from the
    // next occupancy so they line up with count in the same cycle while still
    // coming straight out of flops. Overflow/underflow only look at the
    // request and the current flag, giving a single-cycle pulse per rejected
    // request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            prog_full  <= 1'b0;
            empty      <= 1'b1;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            full       <= (count_next == DEPTH_LVL);
            prog_full  <= (count_next >= PF_LVL);
            empty      <= (count_next == '0);
            prog_empty <= (count_next <= PE_LVL);
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
        end
    end

    // Storage array. Not reset: stale words are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is visible without a request; forced to zero while
            // empty so nothing stale leaks out after a reset or a drain.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = has_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Standard read: the popped word is captured on the pop edge and
            // held until the next accepted read; rd_valid marks the cycle in
            // which a fresh word appears.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    // Structural flag invariants.
    a_full_implies_pf : assert property (@(posedge clk) disable iff (rst)
        full |-> prog_full);
    a_empty_implies_pe : assert property (@(posedge clk) disable iff (rst)
        empty |-> prog_empty);
    a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
        !(full && empty));
    a_count_in_range : assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_LVL);

endmodule

// File: tb/tb_sync_fifo_flags.sv
//------------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Two instances share every input: one standard-read (FWFT=0) and one
// first-word-fall-through (FWFT=1). A queue-based reference model predicts
// occupancy, flags, pulses and read data after every clock edge.
//------------------------------------------------------------------------------
module tb_sync_fifo_flags;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int RESERVE = 4;
    localparam int AE      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;

    logic          s_full, s_prog_full, s_overflow, s_rd_valid;
    logic          s_empty, s_has_data, s_prog_empty, s_underflow;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_count;

    logic          f_full, f_prog_full, f_overflow, f_rd_valid;
    logic          f_empty, f_has_data, f_prog_empty, f_underflow;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_count;

    // Reference model state
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_rd_data;
    bit            model_rd_valid;
    bit            model_overflow;
    bit            model_underflow;
    int            acc_writes;
    int            acc_reads;

    int vec_count   = 0;
    int miscompares = 0;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(RESERVE),
        .AE_LEVEL(AE), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .prog_full(s_prog_full), .overflow(s_overflow),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .empty(s_empty), .has_data(s_has_data), .prog_empty(s_prog_empty),
        .underflow(s_underflow), .count(s_count)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(RESERVE),
        .AE_LEVEL(AE), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .prog_full(f_prog_full), .overflow(f_overflow),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .empty(f_empty), .has_data(f_has_data), .prog_empty(f_prog_empty),
        .underflow(f_underflow), .count(f_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Compares both instances against the model after an edge.
    task automatic checkAll();
        int sz;
        sz = model_q.size();
        checkOutput("count",       32'(s_count),      32'(sz));
        checkOutput("full",        32'(s_full),       32'(sz == DEPTH));
        checkOutput("prog_full",   32'(s_prog_full),  32'(sz >= DEPTH - RESERVE));
        checkOutput("empty",       32'(s_empty),      32'(sz == 0));
        checkOutput("has_data",    32'(s_has_data),   32'(sz != 0));
        checkOutput("prog_empty",  32'(s_prog_empty), 32'(sz <= AE));
        checkOutput("overflow",    32'(s_overflow),   32'(model_overflow));
        checkOutput("underflow",   32'(s_underflow),  32'(model_underflow));
        checkOutput("rd_valid",    32'(s_rd_valid),   32'(model_rd_valid));
        checkOutput("rd_data",     32'(s_rd_data),    32'(model_rd_data));
        checkOutput("balance",     32'(s_count),      32'(acc_writes - acc_reads));
        checkOutput("f_count",     32'(f_count),      32'(sz));
        checkOutput("f_empty",     32'(f_empty),      32'(sz == 0));
        checkOutput("f_overflow",  32'(f_overflow),   32'(model_overflow));
        checkOutput("f_underflow", 32'(f_underflow),  32'(model_underflow));
        checkOutput("f_rd_valid",  32'(f_rd_valid),   32'(sz != 0));
        if (sz != 0) begin
            checkOutput("f_rd_data", 32'(f_rd_data), 32'(model_q[0]));
        end
        checkOutput("inv_full_pf",    32'(!s_full || s_prog_full),   32'd1);
        checkOutput("inv_empty_pe",   32'(!s_empty || s_prog_empty), 32'd1);
        checkOutput("inv_hd_empty",   32'(s_has_data != s_empty),    32'd1);
        checkOutput("inv_not_fe",     32'(!(s_full && s_empty)),     32'd1);
    endtask

    // Drives one cycle of inputs, advances the model, then checks #1 after
    // the rising edge.
    task automatic applyStimulus(input bit rst_v, input bit wr_v, input bit rd_v,
                                 input logic [DW-1:0] d);
        int sz;
        bit wr_acc;
        bit rd_acc;
        @(negedge clk);
        rst     = rst_v;
        wr_en   = wr_v;
        rd_en   = rd_v;
        wr_data = d;
        if (rst_v) begin
            model_q.delete();
            model_rd_data   = '0;
            model_rd_valid  = 1'b0;
            model_overflow  = 1'b0;
            model_underflow = 1'b0;
            acc_writes      = 0;
            acc_reads       = 0;
        end else begin
            sz              = model_q.size();
            wr_acc          = wr_v && (sz < DEPTH);
            rd_acc          = rd_v && (sz > 0);
            model_overflow  = wr_v && (sz == DEPTH);
            model_underflow = rd_v && (sz == 0);
            model_rd_valid  = rd_acc;
            if (rd_acc) begin
                model_rd_data = model_q.pop_front();
                acc_reads++;
            end
            if (wr_acc) begin
                model_q.push_back(d);
                acc_writes++;
            end
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        int p;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        // Reset state
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'hFF);
        applyStimulus(0, 0, 0, 8'h00);

        // Fill 0..15, then one rejected write, then idle to see the pulse drop
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 8'(i));
        applyStimulus(0, 1, 0, 8'h77);
        applyStimulus(0, 0, 0, 8'h00);

        // Drain all sixteen, then one rejected read
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 8'h00);
        applyStimulus(0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);

        // Simultaneous write+read while empty: only the write goes in
        applyStimulus(0, 1, 1, 8'h5A);
        applyStimulus(0, 0, 1, 8'h00);

        // Steady state at eight entries with concurrent traffic
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'($urandom));
        for (int i = 0; i < 100; i++) applyStimulus(0, 1, 1, 8'($urandom));

        // Fill to full, then simultaneous write+read: only the read goes
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'($urandom));
        applyStimulus(0, 1, 1, 8'hEE);
        applyStimulus(0, 0, 0, 8'h00);

        // First-word-fall-through visibility on a fresh FIFO
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 8'hA5);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h00);

        // Mid-operation reset discards contents
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'(8'h10 + i));
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 8'h3C);
        applyStimulus(0, 0, 1, 8'h00);
        applyStimulus(0, 0, 1, 8'h00);

        // Random traffic with alternating bias to reach both extremes
        for (int i = 0; i < 500; i++) begin
            p = ((i / 60) % 2 == 0) ? 70 : 30;
            applyStimulus(0, $urandom_range(99) < p, $urandom_range(99) < (100 - p),
                          8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
